// File: rtl/mc_ctrl_pkg.sv
// Package: mc_ctrl_pkg
// Purpose: Shared constants for the multicycle main-control FSM with memory
//          wait-states: state encodings, opcodes, datapath mux codes and
//          fault codes.
// Ports:   none (package).
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_FETCH  = 4'd0,
    ST_DECODE = 4'd1,
    ST_MEMADR = 4'd2,
    ST_MEMRD  = 4'd3,
    ST_MEMWB  = 4'd4,
    ST_MEMWR  = 4'd5,
    ST_RTYPE  = 4'd6,
    ST_RWB    = 4'd7,
    ST_BEQ    = 4'd8,
    ST_BNE    = 4'd9,
    ST_JUMP   = 4'd10,
    ST_IMMEX  = 4'd11,
    ST_IMMWB  = 4'd12,
    ST_JAL    = 4'd13,
    ST_FAULT  = 4'd15
  } state_e;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_JAL  = 6'h03;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_SLTI = 6'h0A;
  localparam logic [5:0] OP_ANDI = 6'h0C;
  localparam logic [5:0] OP_ORI  = 6'h0D;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;
  localparam logic [1:0] ALU_IMM   = 2'b11;

  localparam logic [1:0] PCS_ALU_RESULT = 2'b00;
  localparam logic [1:0] PCS_ALU_OUT    = 2'b01;
  localparam logic [1:0] PCS_JUMP       = 2'b10;

  localparam logic [1:0] RDST_RT  = 2'b00;
  localparam logic [1:0] RDST_RD  = 2'b01;
  localparam logic [1:0] RDST_R31 = 2'b10;

  localparam logic [1:0] M2R_ALU = 2'b00;
  localparam logic [1:0] M2R_MDR = 2'b01;
  localparam logic [1:0] M2R_PC  = 2'b10;

  localparam logic [1:0] SRCB_RT      = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] FC_NONE    = 2'b00;
  localparam logic [1:0] FC_ILLEGAL = 2'b01;
  localparam logic [1:0] FC_TIMEOUT = 2'b10;

  // States in which the FSM waits on mem_ready and the timeout runs.
  function automatic logic is_wait_state(input state_e s);
    return (s == ST_FETCH) || (s == ST_MEMRD) || (s == ST_MEMWR);
  endfunction

endpackage

// File: rtl/mc_wait_timer.sv
// Module: mc_wait_timer
// Purpose: Bounded memory-wait counter. Counts cycles with tick high and
//          flags expiry on the cycle that would be the MEM_TIMEOUT-th wait.
//          MEM_TIMEOUT=0 disables expiry entirely.
// Ports:
//   clk     in  system clock
//   reset   in  async active-high, clears the count
//   clr     in  synchronous clear (has priority over tick)
//   tick    in  one wait cycle elapsed
//   expired out combinational: count at MEM_TIMEOUT-1 and tick this cycle
module mc_wait_timer #(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic tick,
  output logic expired
);

  localparam int unsigned CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = (MEM_TIMEOUT == 0) ? '0 : CW'(MEM_TIMEOUT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Saturate at LAST so a disabled timer never wraps.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (tick && (cnt_q != LAST)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (MEM_TIMEOUT != 0) && tick && !clr && (cnt_q == LAST);

endmodule

// File: rtl/mc_control_ws.sv
// Module: mc_control_ws
// Purpose: Multicycle MIPS main-control FSM with memory wait-states, bne,
//          immediate ALU ops, optional jal, wait timeout and sticky FAULT.
// Ports:
//   clk, reset (async active-high)       clocking / reset to FETCH
//   op_code[5:0], mem_ready              IR opcode, memory handshake
//   pc_write, pc_write_cond(_ne), pc_source[1:0]      PC control
//   io_d, mem_read, mem_write, ir_write               memory / IR control
//   reg_write, reg_dst[1:0], mem_to_reg[1:0]          register-file control
//   alu_src_a, alu_src_b[1:0], alu_op[1:0]            ALU control
//   state[3:0], fault, fault_code[1:0]                status
//
// state  | meaning
// FETCH  | read instruction at PC, PC+4; waits for mem_ready
// DECODE | branch target into ALUOut, dispatch on opcode
// MEMADR | base + sext imm address for lw/sw
// MEMRD  | data read; waits for mem_ready
// MEMWB  | MDR to rt
// MEMWR  | data write; waits for mem_ready
// RTYPE  | rs op rt
// RWB    | ALUOut to rd
// BEQ    | PC load if equal
// BNE    | PC load if not equal
// JUMP   | PC load jump target
// IMMEX  | rs op sext imm
// IMMWB  | ALUOut to rt
// JAL    | PC load jump target, old PC+4 to r31
// FAULT  | all strobes idle until reset
module mc_control_ws
  import mc_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter bit          EN_JAL      = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op_code,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       pc_write_cond_ne,
  output logic [1:0] pc_source,
  output logic       io_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic [1:0] reg_dst,
  output logic [1:0] mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [3:0] state,
  output logic       fault,
  output logic [1:0] fault_code
);

  state_e     state_q, state_d;
  logic [1:0] fc_q, fc_d;
  logic       in_wait, tmo;

  logic pcw_raw, pcwc_raw, pcwne_raw, mrd_raw, mwr_raw, irw_raw, rw_raw;

  assign in_wait = is_wait_state(state_q);

  mc_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_wait_timer (
    .clk     (clk),
    .reset   (reset),
    .clr     (!in_wait || mem_ready),
    .tick    (in_wait && !mem_ready),
    .expired (tmo)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_FETCH;
      fc_q    <= FC_NONE;
    end else begin
      state_q <= state_d;
      fc_q    <= fc_d;
    end
  end

  // Next state. mem_ready is tested before tmo so a completion in the
  // expiry cycle takes the normal path.
  always_comb begin
    state_d = state_q;
    fc_d    = fc_q;
    case (state_q)
      ST_FETCH: begin
        if (mem_ready) begin
          state_d = ST_DECODE;
        end else if (tmo) begin
          state_d = ST_FAULT;
          fc_d    = FC_TIMEOUT;
        end
      end
      ST_DECODE: begin
        case (op_code)
          OP_R:                            state_d = ST_RTYPE;
          OP_LW, OP_SW:                    state_d = ST_MEMADR;
          OP_BEQ:                          state_d = ST_BEQ;
          OP_BNE:                          state_d = ST_BNE;
          OP_J:                            state_d = ST_JUMP;
          OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI: state_d = ST_IMMEX;
          OP_JAL: begin
            if (EN_JAL) begin
              state_d = ST_JAL;
            end else begin
              state_d = ST_FAULT;
              fc_d    = FC_ILLEGAL;
            end
          end
          default: begin
            state_d = ST_FAULT;
            fc_d    = FC_ILLEGAL;
          end
        endcase
      end
      ST_MEMADR: begin
        // Opcode changing under us after DECODE is treated as illegal.
        if (op_code == OP_LW) begin
          state_d = ST_MEMRD;
        end else if (op_code == OP_SW) begin
          state_d = ST_MEMWR;
        end else begin
          state_d = ST_FAULT;
          fc_d    = FC_ILLEGAL;
        end
      end
      ST_MEMRD: begin
        if (mem_ready) begin
          state_d = ST_MEMWB;
        end else if (tmo) begin
          state_d = ST_FAULT;
          fc_d    = FC_TIMEOUT;
        end
      end
      ST_MEMWR: begin
        if (mem_ready) begin
          state_d = ST_FETCH;
        end else if (tmo) begin
          state_d = ST_FAULT;
          fc_d    = FC_TIMEOUT;
        end
      end
      ST_RTYPE: state_d = ST_RWB;
      ST_IMMEX: state_d = ST_IMMWB;
      ST_MEMWB, ST_RWB, ST_BEQ, ST_BNE, ST_JUMP, ST_IMMWB, ST_JAL: state_d = ST_FETCH;
      ST_FAULT: state_d = ST_FAULT;
      default: begin
        state_d = ST_FAULT;
        fc_d    = FC_ILLEGAL;
      end
    endcase
  end

  // Moore decode of the datapath controls (FETCH ir/pc writes wait on mem_ready).
  always_comb begin
    pcw_raw    = 1'b0;
    pcwc_raw   = 1'b0;
    pcwne_raw  = 1'b0;
    mrd_raw    = 1'b0;
    mwr_raw    = 1'b0;
    irw_raw    = 1'b0;
    rw_raw     = 1'b0;
    pc_source  = PCS_ALU_RESULT;
    io_d       = 1'b0;
    reg_dst    = RDST_RT;
    mem_to_reg = M2R_ALU;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_RT;
    alu_op     = ALU_ADD;
    case (state_q)
      ST_FETCH: begin
        mrd_raw   = 1'b1;
        alu_src_b = SRCB_FOUR;
        irw_raw   = mem_ready;
        pcw_raw   = mem_ready;
      end
      ST_DECODE: alu_src_b = SRCB_IMM_SH2;
      ST_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      ST_MEMRD: begin
        mrd_raw = 1'b1;
        io_d    = 1'b1;
      end
      ST_MEMWB: begin
        rw_raw     = 1'b1;
        mem_to_reg = M2R_MDR;
      end
      ST_MEMWR: begin
        mwr_raw = 1'b1;
        io_d    = 1'b1;
      end
      ST_RTYPE: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_FUNCT;
      end
      ST_RWB: begin
        rw_raw  = 1'b1;
        reg_dst = RDST_RD;
      end
      ST_BEQ, ST_BNE: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_SUB;
        pc_source = PCS_ALU_OUT;
        pcwc_raw  = (state_q == ST_BEQ);
        pcwne_raw = (state_q == ST_BNE);
      end
      ST_JUMP: begin
        pcw_raw   = 1'b1;
        pc_source = PCS_JUMP;
      end
      ST_IMMEX: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        alu_op    = ALU_IMM;
      end
      ST_IMMWB: rw_raw = 1'b1;
      ST_JAL: begin
        // PC still holds PC+4 this cycle, so r31 gets the return address.
        pcw_raw    = 1'b1;
        pc_source  = PCS_JUMP;
        rw_raw     = 1'b1;
        reg_dst    = RDST_R31;
        mem_to_reg = M2R_PC;
      end
      default: ;
    endcase
  end

  // Reset holds state at FETCH, whose decode would otherwise request a read.
  assign pc_write         = pcw_raw   & ~reset;
  assign pc_write_cond    = pcwc_raw  & ~reset;
  assign pc_write_cond_ne = pcwne_raw & ~reset;
  assign mem_read         = mrd_raw   & ~reset;
  assign mem_write        = mwr_raw   & ~reset;
  assign ir_write         = irw_raw   & ~reset;
  assign reg_write        = rw_raw    & ~reset;

  assign state      = state_q;
  assign fault      = (state_q == ST_FAULT);
  assign fault_code = fc_q;

endmodule
